ps2_host_tx: RTL and testbench

PS/2 host-to-device command transmitter for the mouse path. It sends one command byte to the attached PS/2 device, for example 0xF4 (enable data reporting) or 0xFF (reset), using the standard host-to-device handshake: inhibit, request-to-send, device-clocked bits, then device ACK. It shares the PS2_CLK/PS2_DAT lines with the existing mouse receiver. While `busy` is high, the receiver's decoded data is ignored.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_sync_edge.sv | 36 +++
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter (and receiver).
// Holds the transmitter state enum, the mouse command bytes, the default
// timing constants, and helpers for building a frame and sizing the timer.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_REL
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;

    localparam int PS2_CLK_HZ         = 50000000;
    localparam int PS2_INHIBIT_CYCLES = 6000;    // 120 us at 50 MHz
    localparam int PS2_START_TIMEOUT  = 750000;  // 15 ms at 50 MHz
    localparam int PS2_XFER_TIMEOUT   = 100000;  // 2 ms at 50 MHz

    // Outgoing frame after the start bit, LSB first: {stop, odd parity, data}.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

    function automatic int ps2_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchronizer for one PS/2 line plus a falling-edge
// detector on the synchronized value.
//   clk   - system clock
//   rst   - asynchronous active-high reset (lines idle high)
//   pin   - raw PS/2 line
//   level - synchronized line level
//   fall  - high for one cycle when level goes 1 -> 0
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Reset to 1 so releasing reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (mouse path).
// Sends one byte with the inhibit / request-to-send / device-clocked /
// ACK handshake on the shared open-drain PS2_CLK and PS2_DAT lines.
//   CLOCK_50  - system clock
//   reset     - asynchronous active-high reset
//   cmd_data  - command byte, captured on accept
//   cmd_valid - send request; accepted when idle and not in a done/error cycle
//   busy      - transfer in progress (receiver output should be ignored)
//   done      - one-cycle pulse on device ACK
//   error     - one-cycle pulse on missing ACK (or timeout)
//   PS2_CLK   - open-drain clock line, driven 0 or Z
//   PS2_DAT   - open-drain data line, driven 0 or Z
// Build option: define PS2_HOST_TX_TIMEOUT_EN to abort a transfer when the
// device does not start clocking within START_TIMEOUT cycles or does not
// finish within XFER_TIMEOUT cycles of its first clock.
//
// state      | meaning
// IDLE       | lines released, waiting for cmd_valid
// INHIBIT    | CLK held low for INHIBIT_CYCLES
// RTS        | CLK and DAT low for one cycle (request to send)
// START      | CLK released, DAT low (start bit), waiting for device clock
// SHIFT      | placing data, parity and stop bits on each falling edge
// ACK        | sampling device ACK on the 11th falling edge
// WAIT_REL   | waiting for device to release both lines
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = PS2_CLK_HZ,
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = PS2_XFER_TIMEOUT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       busy,
    output logic       done,
    output logic       error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TIMER_MAX = ps2_max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
`else
    localparam int TIMER_MAX = INHIBIT_CYCLES;
`endif
    localparam int TW = $clog2(TIMER_MAX + 1);

    ps2_state_t state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [9:0]    frame, frame_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic          dat_bit, dat_bit_next;
    logic          done_next, error_next;
    logic          clk_low, dat_low;
    logic          clk_level, clk_fall;
    logic          dat_level;

    ps2_sync_edge u_sync_clk (
        .clk   (CLOCK_50),
        .rst   (reset),
        .pin   (PS2_CLK),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_sync_dat (
        .clk   (CLOCK_50),
        .rst   (reset),
        .pin   (PS2_DAT),
        .level (dat_level),
        .fall  ()
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            frame   <= '0;
            bit_cnt <= '0;
            dat_bit <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            frame   <= frame_next;
            bit_cnt <= bit_cnt_next;
            dat_bit <= dat_bit_next;
            done    <= done_next;
            error   <= error_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        frame_next   = frame;
        bit_cnt_next = bit_cnt;
        dat_bit_next = dat_bit;
        done_next    = 1'b0;
        error_next   = 1'b0;
        clk_low      = 1'b0;
        dat_low      = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Saturating down-count; each phase reloads it on entry.
        if (timer != '0) timer_next = timer - 1'b1;
`endif
        unique case (state)
            ST_IDLE: begin
                // A request coinciding with the done/error pulse waits a cycle.
                if (cmd_valid && !done && !error) begin
                    frame_next = ps2_frame(cmd_data);
                    timer_next = TW'(INHIBIT_CYCLES - 1);
                    state_next = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                clk_low = 1'b1;
                if (timer == '0) state_next = ST_RTS;
                else             timer_next = timer - 1'b1;
            end
            ST_RTS: begin
                clk_low    = 1'b1;
                dat_low    = 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                timer_next = TW'(START_TIMEOUT - 1);
`endif
                state_next = ST_START;
            end
            ST_START: begin
                dat_low = 1'b1;
                if (clk_fall) begin
                    dat_bit_next = frame[0];
                    frame_next   = {1'b1, frame[9:1]};
                    bit_cnt_next = 4'd1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    timer_next   = TW'(XFER_TIMEOUT - 1);
`endif
                    state_next   = ST_SHIFT;
                end
`ifdef PS2_HOST_TX_TIMEOUT_EN
                else if (timer == '0) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
`endif
            end
            ST_SHIFT: begin
                dat_low = ~dat_bit;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                if (timer == '0) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else
`endif
                if (clk_fall) begin
                    dat_bit_next = frame[0];
                    frame_next   = {1'b1, frame[9:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    // Falling edge with bit_cnt 9 places the stop bit.
                    if (bit_cnt == 4'd9) state_next = ST_ACK;
                end
            end
            ST_ACK: begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
                if (timer == '0) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else
`endif
                if (clk_fall) begin
                    if (!dat_level) begin
                        state_next = ST_WAIT_REL;
                    end else begin
                        error_next = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT_REL: begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
                if (timer == '0) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end else
`endif
                if (clk_level && dat_level) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Drive decoded from the state register, so reset releases the lines at once.
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a PS/2 device model on pulled-up
// lines. Each accepted command pushes an expected outcome into a queue; the
// device model pushes every frame it captures; a monitor pops both whenever
// done or error pulses and compares against a frame built from the byte.
// Define PS2_HOST_TX_TIMEOUT_EN to also exercise the start timeout.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 40;
    localparam int ST_TO = 300;
    localparam int XF_TO = 2000;
    localparam int H     = 20;   // device half clock period in system cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       busy, done, error;
    wire        ps2_clk, ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST_TO),
        .XFER_TIMEOUT   (XF_TO)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        bit         exp_done;
        bit         has_frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] obs_q[$];
    exp_t        mon_e;
    logic [10:0] mon_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Line values the device should see: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones;
        logic [10:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    always @(negedge clk) begin
        if (!reset && (done || error)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, done, error}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("outcome_done_error", {30'd0, done, error}, mon_e.exp_done ? 32'd2 : 32'd1);
                if (mon_e.has_frame) begin
                    check("frame_seen", 32'(obs_q.size() > 0), 32'd1);
                    if (obs_q.size() > 0) begin
                        mon_f = obs_q.pop_front();
                        check("frame_bits", 32'(mon_f), 32'(model_frame(mon_e.data)));
                    end
                end
            end
        end
    end

    // Raise cmd_valid for one cycle (cycle N); returns in cycle N+1.
    task automatic launch(input logic [7:0] d, input bit exp_done, input bit has_frame);
        @(negedge clk);
        check("idle_before_accept", 32'(busy), 32'd0);
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_q.push_back('{d, exp_done, has_frame});
    endtask

    // Called in cycle N+1; returns in the first START cycle N+2+INH.
    task automatic check_inhibit(input bit poke);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("clk_low_after_accept", 32'(ps2_clk), 32'd0);
        check("dat_free_inhibit", 32'(ps2_dat), 32'd1);
        for (int c = 2; c <= INH; c++) begin
            @(negedge clk);
            if (poke && c == 5) begin
                cmd_data  = 8'h00;
                cmd_valid = 1'b1;
            end else if (poke && c == 8) begin
                cmd_valid = 1'b0;
            end
        end
        check("clk_low_inhibit_end", 32'(ps2_clk), 32'd0);
        check("dat_free_inhibit_end", 32'(ps2_dat), 32'd1);
        @(negedge clk);
        check("rts_clk", 32'(ps2_clk), 32'd0);
        check("rts_dat", 32'(ps2_dat), 32'd0);
        @(negedge clk);
        check("start_clk_released", 32'(ps2_clk), 32'd1);
        check("start_dat_low", 32'(ps2_dat), 32'd0);
    endtask

    // Device model: generates nclk clocks, captures the line before each fall.
    task automatic bfm(input logic [7:0] d, input bit ack, input int nclk,
                       input bit hold, input logic [7:0] nd, input bit nack);
        logic [10:0] cap;
        cap = '0;
        repeat (H) @(negedge clk);
        for (int k = 0; k < nclk; k++) begin
            cap[k] = ps2_dat;
            if (k == 10) begin
                obs_q.push_back(cap);
                if (ack) begin
                    dev_dat_low = 1'b1;
                    @(negedge clk);
                end
            end
            dev_clk_low = 1'b1;
            if (k == 0) begin
                @(negedge clk);
                @(negedge clk);
                check("bit0_not_before_3", 32'(ps2_dat), 32'd0);
                @(negedge clk);
                check("bit0_at_3", 32'(ps2_dat), 32'(d[0]));
                repeat (H - 3) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        if (nclk == 11) begin
            if (ack) begin
                if (hold) begin
                    cmd_data  = nd;
                    cmd_valid = 1'b1;
                end
                dev_dat_low = 1'b0;
                for (int j = 1; j <= 3; j++) begin
                    @(negedge clk);
                    check("done_latency", 32'(done), 32'(j == 3));
                end
                if (hold) begin
                    check("no_accept_in_done_cycle", 32'(busy), 32'd0);
                    @(negedge clk);
                    check("still_idle_next_cycle", 32'(busy), 32'd0);
                    @(negedge clk);
                    cmd_valid = 1'b0;
                    exp_q.push_back('{nd, nack, 1'b1});
                end
            end else begin
                check("lines_free_after_nack", {30'd0, ps2_clk, ps2_dat}, 32'd3);
                check("idle_after_nack", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        bit         rack;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulses", {30'd0, done, error}, 32'd0);
        check("reset_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        launch(PS2_CMD_ENABLE, 1'b1, 1'b1);
        check_inhibit(1'b0);
        bfm(PS2_CMD_ENABLE, 1'b1, 11, 1'b0, 8'h00, 1'b0);

        // 0xFF, with 0xF3 requested across the done cycle; 0xF3 gets no ACK.
        launch(PS2_CMD_RESET, 1'b1, 1'b1);
        check_inhibit(1'b0);
        bfm(PS2_CMD_RESET, 1'b1, 11, 1'b1, PS2_CMD_SET_RATE, 1'b0);
        check_inhibit(1'b0);
        bfm(PS2_CMD_SET_RATE, 1'b0, 11, 1'b0, 8'h00, 1'b0);
        repeat (5) @(negedge clk);

        // Second request (0x00) during INHIBIT must be dropped.
        launch(PS2_CMD_ENABLE, 1'b1, 1'b1);
        check_inhibit(1'b1);
        bfm(PS2_CMD_ENABLE, 1'b1, 11, 1'b0, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        check("no_queued_request", 32'(busy), 32'd0);

        // Reset while bit 4 (a 0) is on the line.
        launch(8'hE0, 1'b1, 1'b1);
        check_inhibit(1'b0);
        bfm(8'hE0, 1'b1, 5, 1'b0, 8'h00, 1'b0);
        check("bit4_driven_low", 32'(ps2_dat), 32'd0);
        reset = 1'b1;
        #1;
        check("reset_mid_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        check("reset_mid_outputs", {29'd0, busy, done, error}, 32'd0);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        launch(PS2_CMD_ENABLE, 1'b1, 1'b1);
        check_inhibit(1'b0);
        bfm(PS2_CMD_ENABLE, 1'b1, 11, 1'b0, 8'h00, 1'b0);

        for (int n = 0; n < 8; n++) begin
            rd   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            launch(rd, rack, 1'b1);
            check_inhibit(1'b0);
            bfm(rd, rack, 11, 1'b0, 8'h00, 1'b0);
        end

`ifdef PS2_HOST_TX_TIMEOUT_EN
        repeat (4) @(negedge clk);
        launch(PS2_CMD_ENABLE, 1'b0, 1'b0);
        check_inhibit(1'b0);
        for (int i = 1; i <= ST_TO; i++) begin
            @(negedge clk);
            if (i == ST_TO - 1) check("no_early_timeout", 32'(error), 32'd0);
            if (i == ST_TO) begin
                check("start_timeout_error", 32'(error), 32'd1);
                check("timeout_lines_free", {30'd0, ps2_clk, ps2_dat}, 32'd3);
            end
        end
`endif

        repeat (10) @(negedge clk);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        check("pending_frames", 32'(obs_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
